seq_mul_ct: RTL and testbench

Parametrised sequential shift-and-add multiplier with valid/ready handshakes on input and output, selectable signed/unsigned operation per transaction, and a build-time choice between constant-time and early-exit iteration. It replaces the fixed-width 4-bit multiplier used as a design-under-test in our self-composition (two-copy) timing-leakage checks. With `CONST_TIME=1`, completion timing must be provably independent of operand values. With `CONST_TIME=0`, it is the deliberately leaky variant those checks must flag.

---
 rtl/seq_mul_ct.sv | 62 ++++++
 tb/tb_seq_mul_ct.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_ct.sv
// seq_mul_ct: sequential shift-and-add multiplier with constant-time or early-exit iteration
module seq_mul_ct #(
   parameter int WIDTH = 4,
   parameter bit CONST_TIME = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic [2*WIDTH-1:0] o,
   output logic               out_valid,
   input  logic               out_ready
);
   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic neg, last;
   logic [DW-1:0] acc, acc_nx;
   logic [CW-1:0] cnt;
   assign in_ready = (state == IDLE) && !rst;
   assign out_valid = state == DONE;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   // next state, this cycle's partial sum and the exit decision
   always_comb begin
      acc_nx = acc + (b_mag[0] ? (DW'(a_mag) << cnt) : '0);
      last = (cnt == LAST) || (!CONST_TIME && (b_mag[WIDTH-1:1] == '0 || a_mag == '0));
      state_nx = state;
      if (state == IDLE && in_valid) state_nx = BUSY;
      else if (state == BUSY && last) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   // operand capture, one multiplier bit per busy cycle, sign fix-up on exit
   always_ff @(posedge clk) begin
      if (rst) begin
         o <= '0;
         acc <= '0;
         cnt <= '0;
         a_mag <= '0;
         b_mag <= '0;
         neg <= 1'b0;
      end else if (in_valid && in_ready) begin
         a_mag <= (signed_mode && a[WIDTH-1]) ? -a : a;
         b_mag <= (signed_mode && b[WIDTH-1]) ? -b : b;
         neg <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
         acc <= '0;
         cnt <= '0;
      end else if (state == BUSY) begin
         acc <= acc_nx;
         b_mag <= b_mag >> 1;
         cnt <= cnt + CW'(1);
         if (last) o <= neg ? -acc_nx : acc_nx;
      end
   end
endmodule

// File: tb/tb_seq_mul_ct.sv
// tb_seq_mul_ct: randomized and directed checks of seq_mul_ct against a transaction-level model
module tb_seq_mul_ct;
   localparam int W = 4;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, signed_mode = 0;
   logic [W-1:0] a1 = 0, a2 = 0, b = 0;
   logic ov [4];
   logic ir [4];
   logic [2*W-1:0] oo [4];
   int checks = 0, errors = 0;
   int lat_ct, lat_ee;
   bit div;
   always #5 clk = ~clk;

   seq_mul_ct #(.WIDTH(W), .CONST_TIME(1)) u_ct1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a1), .b(b), .signed_mode(signed_mode), .o(oo[0]), .out_valid(ov[0]), .out_ready(out_ready));
   seq_mul_ct #(.WIDTH(W), .CONST_TIME(1)) u_ct2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a2), .b(b), .signed_mode(signed_mode), .o(oo[1]), .out_valid(ov[1]), .out_ready(out_ready));
   seq_mul_ct #(.WIDTH(W), .CONST_TIME(0)) u_ee1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a1), .b(b), .signed_mode(signed_mode), .o(oo[2]), .out_valid(ov[2]), .out_ready(out_ready));
   seq_mul_ct #(.WIDTH(W), .CONST_TIME(0)) u_ee2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
      .a(a2), .b(b), .signed_mode(signed_mode), .o(oo[3]), .out_valid(ov[3]), .out_ready(out_ready));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm);
      int xi = sm ? int'($signed(x)) : int'(x);
      int yi = sm ? int'($signed(y)) : int'(y);
      return (2*W)'(xi * yi);
   endfunction

   function automatic int lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm, input bit ee);
      int am = (sm && x[W-1]) ? (1 << W) - int'(x) : int'(x);
      int bm = (sm && y[W-1]) ? (1 << W) - int'(y) : int'(y);
      int h = 0;
      if (!ee) return W + 1;
      if (am == 0) return 2;
      for (int k = 0; k < W; k++) if (((bm >> k) & 1) == 1) h = k;
      return h + 2;
   endfunction

   int ecnt = 0;
   bit live = 0;
   int m_st [4];
   int m_due [4];
   logic [2*W-1:0] m_o [4];
   logic [2*W-1:0] m_p [4];
   // transaction-level model: each accepted operation completes L cycles after its handshake
   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      if (rst) begin
         live <= 1;
         for (int i = 0; i < 4; i++) begin
            m_st[i] <= 0;
            m_o[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_st[i] == 0 && in_valid) begin
               m_st[i] <= 1;
               m_due[i] <= ecnt + lat(i[0] ? a2 : a1, b, signed_mode, i >= 2);
               m_p[i] <= prod(i[0] ? a2 : a1, b, signed_mode);
            end else if (m_st[i] == 1 && ecnt + 1 == m_due[i]) begin
               m_st[i] <= 2;
               m_o[i] <= m_p[i];
            end else if (m_st[i] == 2 && out_ready) m_st[i] <= 0;
         end
      end
   end

   // compare every instance against the model on every cycle
   always @(negedge clk) begin
      if (live) begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("out_valid%0d", i), ov[i], m_st[i] == 2);
            check($sformatf("in_ready%0d", i), ir[i], m_st[i] == 0 && !rst);
            check($sformatf("o%0d", i), oo[i], m_o[i]);
         end
         check("ct_pair_out_valid", ov[1], ov[0]);
      end
   end

   task automatic op(input logic [W-1:0] x1, input logic [W-1:0] x2, input logic [W-1:0] y,
                     input bit sm, input int hold);
      a1 = x1; a2 = x2; b = y; signed_mode = sm; in_valid = 1;
      check("hs_ready", ir[0], 1);
      @(posedge clk); #1;
      in_valid = 0; a1 = W'($urandom); a2 = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
      lat_ct = 0; lat_ee = 0; div = 0;
      for (int n = 1; n <= 3 * W && lat_ct == 0; n++) begin
         out_ready = (hold == 0) ? 1'($urandom) : 1'b0;
         @(posedge clk); #1;
         if (ov[0]) lat_ct = n + 1;
         if (ov[2] && lat_ee == 0) lat_ee = n + 1;
         if (ov[2] != ov[3]) div = 1;
      end
      out_ready = 0;
      check("op_done", lat_ct != 0, 1);
      for (int n = 0; n < hold; n++) begin
         in_valid = 1; a1 = W'($urandom); a2 = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         check("bp_in_ready", ir[0], 0);
         check("bp_out_valid", ov[0], 1);
         check("bp_o", oo[0], prod(x1, y, sm));
         if (ov[2] != ov[3]) div = 1;
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("ready_after_take", ir[0], 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", ov[0], 0);
      check("rst_o", oo[0], 0);
      check("rst_in_ready", ir[0], 0);
      rst = 0; #1;
      check("post_rst_in_ready", ir[0], 1);
      op(13, 13, 11, 0, 0);
      check("u13x11", oo[0], 143); check("u13x11_lat", lat_ct, 5); check("u13x11_ee_lat", lat_ee, 5);
      op(0, 0, 0, 0, 0);
      check("u0x0", oo[0], 0); check("u0x0_lat", lat_ct, 5); check("u0x0_ee_lat", lat_ee, 2);
      op(4'b1000, 4'b1000, 4'b1000, 1, 0);
      check("s_min_min", oo[0], 8'h40); check("s_min_min_lat", lat_ct, 5);
      op(4'hD, 4'hD, 5, 1, 0);
      check("s_m3x5", oo[0], 8'hF1); check("s_m3x5_lat", lat_ct, 5);
      op(7, 7, 4'hF, 1, 0);
      check("s_7xm1", oo[0], 8'hF9); check("s_7xm1_lat", lat_ct, 5);
      op(8, 8, 8, 0, 0);
      check("u8x8", oo[0], 8'h40);
      op(13, 13, 5, 0, 0);
      check("u13x5", oo[0], 8'h41);
      op(5, 5, 1, 0, 0);
      check("ee_b1_lat", lat_ee, 2); check("ee_b1_o", oo[2], 5);
      op(5, 5, 8, 0, 0);
      check("ee_b8_lat", lat_ee, 5); check("ee_b8_o", oo[2], 40);
      op(5, 5, 3, 0, 0);
      check("ee_b3_lat", lat_ee, 3);
      op(0, 0, 15, 0, 0);
      check("ee_a0_lat", lat_ee, 2); check("ee_a0_o", oo[2], 0);
      op(5, 5, 4'b1000, 1, 0);
      check("ee_sb_m8_lat", lat_ee, 5); check("ee_sb_m8_o", oo[2], 8'hD8);
      op(9, 9, 6, 0, 10);
      check("bp_result", oo[0], 54);
      op(11, 11, 3, 0, 0);
      check("after_bp", oo[0], 33);
      a1 = 9; a2 = 9; b = 14; signed_mode = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; #1;
      check("abort_out_valid", ov[0], 0);
      check("abort_o", oo[0], 0);
      check("abort_in_ready", ir[0], 1);
      op(5, 5, 6, 0, 0);
      check("after_abort", oo[0], 30); check("after_abort_lat", lat_ct, 5);
      rst = 1; in_valid = 1; a1 = 3; b = 3;
      @(posedge clk); #1;
      rst = 0; in_valid = 0;
      repeat (6) @(posedge clk);
      #1;
      check("rst_with_valid_no_op", ov[0], 0);
      for (int t = 0; t < 1000; t++) begin
         logic [W-1:0] x;
         x = W'($urandom);
         op(x, x ^ W'($urandom_range(1, (1 << W) - 1)), W'($urandom), 1'($urandom), $urandom_range(0, 2));
         check("rand_lat_ct", lat_ct, W + 1);
      end
      op(0, 3, 15, 0, 0);
      check("ee_pair_diverges", div, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
